// File: rtl/num_ascii_pkg.sv
// Shared types and constants for the binary-to-decimal ASCII stream converter.
// NUM_TO_ASCII_NEWLINE_EN adds a trailing newline state.
package num_ascii_pkg;

`ifdef NUM_TO_ASCII_NEWLINE_EN
  typedef enum logic [2:0] {StIdle, StConvert, StSkip, StEmit, StNewline} state_e;
`else
  typedef enum logic [2:0] {StIdle, StConvert, StSkip, StEmit} state_e;
`endif

  localparam logic [7:0]  ASCII_ZERO  = 8'h30;
  localparam logic [7:0]  ASCII_NL    = 8'h0A;
  localparam int unsigned BCD_DIGITS  = 20;
  localparam int unsigned IN_WIDTH    = 64;
  localparam int unsigned CONV_CYCLES = 64;
  localparam int unsigned BCD_WIDTH   = 4 * BCD_DIGITS;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: digits of 5 or more get 3 added before the shift.
module bcd_add3 #(
  parameter int unsigned UUID = 0
) (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  assign digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;

endmodule

// File: rtl/number_to_ascii_stream.sv
// Converts a 64-bit unsigned value to a decimal ASCII byte stream, MSD first, no leading zeros.
// Define NUM_TO_ASCII_NEWLINE_EN to append 8'h0A after the units digit.
module number_to_ascii_stream
  import num_ascii_pkg::*;
#(
  parameter int unsigned UUID = 0,
  parameter string       NAME = ""
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_WIDTH-1:0] in_value,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [7:0]          out_byte,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                out_last
);

  localparam logic [5:0] CntLast   = 6'(CONV_CYCLES - 1);
  localparam logic [4:0] IdxLast   = 5'(BCD_DIGITS - 1);
  localparam logic [4:0] IdxPenult = 5'(BCD_DIGITS - 2);

  state_e                 state_q, state_d;
  logic [IN_WIDTH-1:0]    shift_q, shift_d;
  logic [BCD_WIDTH-1:0]   bcd_q, bcd_d;
  logic [BCD_WIDTH-1:0]   bcd_adj;
  logic [5:0]             cnt_q, cnt_d;
  logic [4:0]             idx_q, idx_d;
  logic [3:0]             top_digit;
  logic [3:0]             next_digit;

  for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
    bcd_add3 #(
      .UUID(UUID ^ 32'(g + 1))
    ) u_add3 (
      .digit_i(bcd_q[4*g +: 4]),
      .digit_o(bcd_adj[4*g +: 4])
    );
  end

  assign top_digit  = bcd_q[BCD_WIDTH-1 -: 4];
  assign next_digit = bcd_q[BCD_WIDTH-5 -: 4];

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          shift_d = in_value;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = StConvert;
        end
      end
      StConvert: begin
        {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == CntLast) begin
          idx_d   = '0;
          state_d = StSkip;
        end
      end
      StSkip: begin
        // Look one digit ahead so a run of z zeros costs exactly z cycles.
        if (top_digit == 4'd0 && idx_q != IdxLast) begin
          bcd_d = bcd_q << 4;
          idx_d = idx_q + 5'd1;
          if (next_digit != 4'd0 || idx_q == IdxPenult) begin
            state_d = StEmit;
          end
        end else begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (idx_q == IdxLast) begin
`ifdef NUM_TO_ASCII_NEWLINE_EN
            state_d = StNewline;
`else
            state_d = StIdle;
`endif
          end else begin
            bcd_d = bcd_q << 4;
            idx_d = idx_q + 5'd1;
          end
        end
      end
`ifdef NUM_TO_ASCII_NEWLINE_EN
      StNewline: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = 1'b0;
    out_byte  = 8'h00;
    out_last  = 1'b0;
    unique case (state_q)
      StEmit: begin
        out_valid = 1'b1;
        out_byte  = ASCII_ZERO + {4'h0, top_digit};
`ifndef NUM_TO_ASCII_NEWLINE_EN
        out_last  = (idx_q == IdxLast);
`endif
      end
`ifdef NUM_TO_ASCII_NEWLINE_EN
      StNewline: begin
        out_valid = 1'b1;
        out_byte  = ASCII_NL;
        out_last  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      shift_q <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

endmodule

// File: tb/tb_number_to_ascii_stream.sv
// Scoreboard bench for number_to_ascii_stream: expected bytes queued at send, checked on handshake.
module tb_number_to_ascii_stream;

  logic        clk;
  logic        rst;
  logic [63:0] in_value;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int n_checks = 0;
  int n_fail   = 0;

  logic [8:0] exp_q[$];  // {last, byte}
  logic       stall_q = 1'b0;
  logic [8:0] stall_val;

  number_to_ascii_stream #(
    .UUID(0),
    .NAME("dut")
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_value (in_value),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_byte (out_byte),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference decimal model; returns the number of digits.
  task automatic push_expected(input logic [63:0] v, output int ndig);
    logic [63:0] r;
    logic [7:0]  d[$];
    logic        last;
    r = v;
    do begin
      d.push_front(8'h30 + 8'(r % 64'd10));
      r = r / 64'd10;
    end while (r != 64'd0);
    ndig = d.size();
    for (int i = 0; i < d.size(); i++) begin
`ifdef NUM_TO_ASCII_NEWLINE_EN
      last = 1'b0;
`else
      last = (i == d.size() - 1);
`endif
      exp_q.push_back({last, d[i]});
    end
`ifdef NUM_TO_ASCII_NEWLINE_EN
    exp_q.push_back({1'b1, 8'h0A});
`endif
  endtask

  // Returns at posedge+1 after the accept edge, or at the negedge of first out_valid when lat != 0.
  task automatic send(input logic [63:0] v, input int lat);
    int ndig;
    int n;
    @(posedge clk);
    #1;
    push_expected(v, ndig);
    in_value = v;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    check_eq("accept", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (lat != 0) begin
      n = 0;
      while (n < 200) begin
        @(negedge clk);
        if (out_valid) break;
        @(posedge clk);
        n++;
      end
      check_eq("latency", 64'(n), 64'(lat));
    end
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && in_ready) begin
        done = 1'b1;
        break;
      end
    end
    check_eq("drain", {63'd0, done}, 64'd1);
  endtask

  always @(negedge clk) begin
    if (stall_q) begin
      check_eq("stall_valid", {63'd0, out_valid}, 64'd1);
      check_eq("stall_hold", {55'd0, out_last, out_byte}, {55'd0, stall_val});
    end
    stall_q <= 1'b0;
    if (rst && out_valid) begin
      check_eq("in_ready_busy", {63'd0, in_ready}, 64'd0);
      if (!out_ready) begin
        stall_q   <= 1'b1;
        stall_val <= {out_last, out_byte};
      end
    end
    if (rst && out_valid && out_ready) begin
      check_eq("sb_pending", {63'd0, (exp_q.size() > 0)}, 64'd1);
      if (exp_q.size() > 0) begin
        logic [8:0] e;
        e = exp_q.pop_front();
        check_eq("out_byte", {56'd0, out_byte}, {56'd0, e[7:0]});
        check_eq("out_last", {63'd0, out_last}, {63'd0, e[8]});
      end
    end
  end

  initial begin
    int k;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_out_byte", {56'd0, out_byte}, 64'd0);
    check_eq("rst_out_last", {63'd0, out_last}, 64'd0);
    rst = 1'b1;

    // Zero: 19 skipped digits, units digit always emitted.
    send(64'd0, 64 + 19);
    wait_idle();
    send(64'd1234, 64 + 16);
    wait_idle();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64 + 1);
    wait_idle();

    // Backpressure with out_ready pattern 1,0,0,...
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(64'd907, 64 + 17);
    k = 0;
    while (k < 300 && !(exp_q.size() == 0 && in_ready)) begin
      @(posedge clk);
      #1;
      out_ready = (k % 3 == 0);
      k++;
    end
    check_eq("stall_drain", {63'd0, (exp_q.size() == 0)}, 64'd1);
    out_ready = 1'b1;

    // A second value offered during conversion must be ignored.
    send(64'd42, 0);
    repeat (10) @(posedge clk);
    #1;
    check_eq("busy_in_ready", {63'd0, in_ready}, 64'd0);
    in_value = 64'd55;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_idle();
    repeat (100) @(negedge clk);
    check_eq("no_extra", {63'd0, out_valid}, 64'd0);

    // Reset in the middle of emitting 98765 after two bytes.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    send(64'd98765, 64 + 15);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    rst       = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
`ifdef NUM_TO_ASCII_NEWLINE_EN
    check_eq("abandon_left", 64'(exp_q.size()), 64'd4);
`else
    check_eq("abandon_left", 64'(exp_q.size()), 64'd3);
`endif
    exp_q.delete();
    check_eq("abandon_valid", {63'd0, out_valid}, 64'd0);
    check_eq("abandon_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    send(64'd7, 64 + 19);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
